// File: rtl/button_pkg.sv
// Shared definitions for the board push-button conditioning logic.
// Holds the debouncer state encoding and the 12 MHz timing defaults.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } state_t;

    localparam int CLOCK_HZ                  = 12_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES   = 120_000;     // 10 ms
    localparam int DEFAULT_LONG_PRESS_CYCLES = 12_000_000;  // 1 s

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
// Shared by both board buttons.
module sync_2ff (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic sync_1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            q      <= 1'b0;
        end else begin
            sync_1 <= d;
            q      <= sync_1;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button pin into a stable level, press/release/long-press
// strobes and a wrapping press counter.
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       button_raw,
    output logic       button_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press_pulse,
    output logic [7:0] press_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_PRESS_CYCLES - 2);

    logic              sync_2;
    state_t            state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    sync_2ff u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (button_raw),
        .q       (sync_2)
    );

    // Strobes default low every cycle so each fires for exactly one clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= RELEASED;
            db_cnt           <= '0;
            hold_cnt         <= '0;
            button_level     <= 1'b0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
            press_count      <= 8'd0;
        end else begin
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    if (sync_2) begin
                        state  <= PRESS_PENDING;
                        db_cnt <= '0;
                    end
                end
                PRESS_PENDING: begin
                    if (!sync_2) begin
                        state <= RELEASED;
                    end else if (db_cnt == DB_LAST) begin
                        state        <= PRESSED;
                        button_level <= 1'b1;
                        press_pulse  <= 1'b1;
                        press_count  <= press_count + 8'd1;
                        hold_cnt     <= '0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sync_2) begin
                        state  <= RELEASE_PENDING;
                        db_cnt <= '0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        // Saturating here is what limits long-press to one firing.
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_PRE) begin
                            long_press_pulse <= 1'b1;
                        end
                    end
                end
                RELEASE_PENDING: begin
                    if (sync_2) begin
                        state <= PRESSED;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= RELEASED;
                        button_level  <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
// Expected strobes are queued with their edge number and checked as they appear.
module tb_button_debouncer;

    localparam int DB = 4;
    localparam int LP = 10;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    typedef struct {
        int         kind;
        int         edge_n;
        logic [7:0] count;
    } ev_t;

    logic       clock;
    logic       reset_n;
    logic       button_raw;
    logic       button_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press_pulse;
    logic [7:0] press_count;

    int         compared;
    int         mismatched;
    int         edge_num;
    int         press_seen;
    int         release_seen;
    int         long_seen;
    int         n_pulses;
    logic [7:0] count_model;
    ev_t        sb[$];
    ev_t        got;

    button_debouncer #(
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .button_raw       (button_raw),
        .button_level     (button_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse),
        .press_count      (press_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_num <= edge_num + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: run still active, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every strobe seen must match the next queued expectation exactly.
    always @(negedge clock) begin
        if (reset_n) begin
            n_pulses = int'(press_pulse) + int'(release_pulse) + int'(long_press_pulse);
            if (n_pulses != 0) begin
                compared++;
                if (press_pulse)      press_seen++;
                if (release_pulse)    release_seen++;
                if (long_press_pulse) long_seen++;
                if (n_pulses > 1) begin
                    mismatched++;
                    $display("[TB] FAIL exclusive_pulses: %0d strobes high at edge %0d, required 1",
                             n_pulses, edge_num);
                end else if (sb.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_pulse: p/r/l=%b%b%b at edge %0d, required none",
                             press_pulse, release_pulse, long_press_pulse, edge_num);
                end else begin
                    got = sb.pop_front();
                    if ((got.kind == K_PRESS   && !press_pulse)   ||
                        (got.kind == K_RELEASE && !release_pulse) ||
                        (got.kind == K_LONG    && !long_press_pulse) ||
                        got.edge_n != edge_num || got.count !== press_count ||
                        button_level !== (got.kind != K_RELEASE)) begin
                        mismatched++;
                        $display("[TB] FAIL pulse_event: got p/r/l=%b%b%b edge %0d count %0d level %b, required kind %0d edge %0d count %0d",
                                 press_pulse, release_pulse, long_press_pulse, edge_num,
                                 press_count, button_level, got.kind, got.edge_n, got.count);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset_n    = 1'b0;
        button_raw = 1'b0;
        repeat (2) @(negedge clock);
        reset_n     = 1'b1;
        count_model = 8'd0;
        repeat (2) @(negedge clock);
    endtask

    task automatic press_and_release(input int hold, input int gap);
        int s;
        @(negedge clock);
        s          = edge_num;
        button_raw = 1'b1;
        count_model++;
        sb.push_back('{K_PRESS, s + DB + 3, count_model});
        if (hold >= 14) sb.push_back('{K_LONG, s + DB + 3 + LP - 1, count_model});
        sb.push_back('{K_RELEASE, s + hold + DB + 3, count_model});
        repeat (hold) @(negedge clock);
        button_raw = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        button_raw = 1'b0;
        repeat (3) @(negedge clock);
        compared++;
        if (button_level !== 1'b0 || press_count !== 8'd0 || press_pulse !== 1'b0 ||
            release_pulse !== 1'b0 || long_press_pulse !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_values: level %b count %0d p/r/l=%b%b%b, required all 0",
                     button_level, press_count, press_pulse, release_pulse, long_press_pulse);
        end
        @(negedge clock);
        reset_n     = 1'b1;
        count_model = 8'd0;
        repeat (4) @(negedge clock);
        compared++;
        if (button_level !== 1'b0 || press_count !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL idle_after_reset: level %b count %0d, required 0/0",
                     button_level, press_count);
        end
    endtask

    task automatic test_clean_press();
        int s;
        do_reset();
        @(negedge clock);
        s          = edge_num;
        button_raw = 1'b1;
        count_model++;
        sb.push_back('{K_PRESS, s + 7, count_model});
        sb.push_back('{K_LONG, s + 16, count_model});
        sb.push_back('{K_RELEASE, s + 27, count_model});
        repeat (6) @(negedge clock);
        compared++;
        if (button_level !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL press_early: level %b at edge 6, required 0", button_level);
        end
        @(negedge clock);
        compared++;
        if (button_level !== 1'b1 || press_pulse !== 1'b1 || press_count !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL press_edge7: level %b pulse %b count %0d, required 1/1/1",
                     button_level, press_pulse, press_count);
        end
        @(negedge clock);
        compared++;
        if (button_level !== 1'b1 || press_pulse !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL press_width: level %b pulse %b, required 1/0",
                     button_level, press_pulse);
        end
        repeat (12) @(negedge clock);
        button_raw = 1'b0;
        repeat (6) @(negedge clock);
        compared++;
        if (button_level !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL release_early: level %b, required 1", button_level);
        end
        @(negedge clock);
        compared++;
        if (button_level !== 1'b0 || release_pulse !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL release_edge7: level %b pulse %b, required 0/1",
                     button_level, release_pulse);
        end
        repeat (8) @(negedge clock);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL clean_missing: %0d events outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_bounce();
        int s;
        int p0;
        do_reset();
        p0 = press_seen;
        @(negedge clock);
        s = edge_num;
        count_model++;
        sb.push_back('{K_PRESS, s + 15, count_model});
        sb.push_back('{K_RELEASE, s + 25, count_model});
        for (int i = 0; i < 4; i++) begin
            button_raw = (i % 2 == 0);
            repeat (2) @(negedge clock);
        end
        button_raw = 1'b1;
        compared++;
        if (button_level !== 1'b0 || press_seen != p0) begin
            mismatched++;
            $display("[TB] FAIL bounce_quiet: level %b presses %0d, required 0/0",
                     button_level, press_seen - p0);
        end
        repeat (10) @(negedge clock);
        button_raw = 1'b0;
        repeat (15) @(negedge clock);
        compared++;
        if (sb.size() != 0 || press_count !== 8'd1 || press_seen - p0 != 1) begin
            mismatched++;
            $display("[TB] FAIL bounce_result: outstanding %0d count %0d presses %0d, required 0/1/1",
                     sb.size(), press_count, press_seen - p0);
        end
    endtask

    task automatic test_long_press();
        int l0;
        do_reset();
        l0 = long_seen;
        press_and_release(30, 12);
        compared++;
        if (long_seen - l0 != 1 || sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL long_once: long pulses %0d outstanding %0d, required 1/0",
                     long_seen - l0, sb.size());
        end
    endtask

    task automatic test_glitch();
        int   s;
        int   r0;
        int   l0;
        logic held;
        do_reset();
        r0   = release_seen;
        l0   = long_seen;
        held = 1'b1;
        @(negedge clock);
        s          = edge_num;
        button_raw = 1'b1;
        count_model++;
        sb.push_back('{K_PRESS, s + 7, count_model});
        sb.push_back('{K_LONG, s + 16, count_model});
        sb.push_back('{K_RELEASE, s + 47, count_model});
        repeat (20) @(negedge clock);
        button_raw = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (button_level !== 1'b1) held = 1'b0;
        end
        button_raw = 1'b1;
        repeat (7) begin
            @(negedge clock);
            if (button_level !== 1'b1) held = 1'b0;
        end
        compared++;
        if (held !== 1'b1 || release_seen != r0) begin
            mismatched++;
            $display("[TB] FAIL glitch_hold: level stayed %b releases %0d, required 1/0",
                     held, release_seen - r0);
        end
        repeat (10) @(negedge clock);
        button_raw = 1'b0;
        repeat (12) @(negedge clock);
        compared++;
        if (sb.size() != 0 || long_seen - l0 != 1 || release_seen - r0 != 1) begin
            mismatched++;
            $display("[TB] FAIL glitch_result: outstanding %0d long %0d release %0d, required 0/1/1",
                     sb.size(), long_seen - l0, release_seen - r0);
        end
    endtask

    task automatic test_wrap();
        int p0;
        do_reset();
        p0 = press_seen;
        repeat (256) press_and_release(8, 10);
        compared++;
        if (press_count !== 8'd0 || press_seen - p0 != 256 || sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL count_wrap: count %0d presses %0d outstanding %0d, required 0/256/0",
                     press_count, press_seen - p0, sb.size());
        end
    endtask

    task automatic test_reset_mid_press();
        int s;
        int r;
        int r0;
        do_reset();
        r0 = release_seen;
        @(negedge clock);
        s          = edge_num;
        button_raw = 1'b1;
        count_model++;
        sb.push_back('{K_PRESS, s + 7, count_model});
        repeat (10) @(negedge clock);
        compared++;
        if (button_level !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mid_press_setup: level %b, required 1", button_level);
        end
        #2;
        reset_n = 1'b0;
        #1;
        compared++;
        if (button_level !== 1'b0 || press_count !== 8'd0 || press_pulse !== 1'b0 ||
            release_pulse !== 1'b0 || long_press_pulse !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset: level %b count %0d p/r/l=%b%b%b, required all 0",
                     button_level, press_count, press_pulse, release_pulse, long_press_pulse);
        end
        count_model = 8'd0;
        repeat (3) @(negedge clock);
        r       = edge_num;
        reset_n = 1'b1;
        count_model++;
        sb.push_back('{K_PRESS, r + 7, count_model});
        sb.push_back('{K_RELEASE, r + 17, count_model});
        repeat (10) @(negedge clock);
        button_raw = 1'b0;
        repeat (12) @(negedge clock);
        compared++;
        if (sb.size() != 0 || press_count !== 8'd1 || release_seen - r0 != 1) begin
            mismatched++;
            $display("[TB] FAIL reset_repress: outstanding %0d count %0d releases %0d, required 0/1/1",
                     sb.size(), press_count, release_seen - r0);
        end
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        edge_num     = 0;
        press_seen   = 0;
        release_seen = 0;
        long_seen    = 0;
        count_model  = 8'd0;
        reset_n      = 1'b0;
        button_raw   = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_glitch();
        test_wrap();
        test_reset_mid_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw mechanical push-button input into clean, glitch-free signals for the board's 12 MHz domain. It synchronises the asynchronous pin and debounces it with a four-state machine. Outputs are a stable level, single-cycle press/release/long-press strobes and a wrapping press counter. It sits between the GPIO button pin and the 8-bit LED shift register: `button_level` drives the serial data input and `press_pulse` can serve as the shift enable.

## Interface
- `DEBOUNCE_CYCLES`, default 120000: consecutive stable clocks required to accept a change (10 ms at 12 MHz); legal range ≥ 2.
- `LONG_PRESS_CYCLES`, default 12000000: clocks a debounced press must be held before `long_press_pulse` fires (1 s); legal range ≥ 2.
- `clock`  in  1: 12 MHz clock; all state on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `button_raw`  in  1: unsynchronised pin, active-high (1 = pressed).
- `button_level`  out  1: debounced level, registered.
- `press_pulse`  out  1: one-cycle strobe on accepted press.
- `release_pulse`  out  1: one-cycle strobe on accepted release.
- `long_press_pulse`  out  1: one-cycle strobe, at most once per press.
- `press_count`  out  8: count of accepted presses, wraps 255→0.

## Operation
- Synchroniser: two flops, `button_raw` → `sync_1` → `sync_2`; both reset to 0. The FSM uses only `sync_2`.
- States: RELEASED (reset), PRESS_PENDING, PRESSED, RELEASE_PENDING.
- RELEASED:
  - `sync_2`=1 → PRESS_PENDING, `db_cnt`←0.
  - Otherwise hold.
- PRESS_PENDING:
  - `sync_2`=0 → RELEASED. This is a bounce; no outputs change.
  - `sync_2`=1 and `db_cnt`==DEBOUNCE_CYCLES−1 → PRESSED. `button_level`←1, `press_pulse`←1, `press_count`←`press_count`+1, `hold_cnt`←0.
  - Otherwise `db_cnt`++.
- PRESSED:
  - `sync_2`=0 → RELEASE_PENDING, `db_cnt`←0.
  - Otherwise `hold_cnt`++ until it saturates at LONG_PRESS_CYCLES−1. On the single edge where `hold_cnt` goes LONG_PRESS_CYCLES−2 → LONG_PRESS_CYCLES−1, `long_press_pulse`←1.
- RELEASE_PENDING:
  - `sync_2`=1 → PRESSED. This is a bounce: `hold_cnt` is not cleared, and there is no pulse and no count change.
  - `sync_2`=0 and `db_cnt`==DEBOUNCE_CYCLES−1 → RELEASED. `button_level`←0, `release_pulse`←1.
  - Otherwise `db_cnt`++.
- Counter widths: `db_cnt` is clog2(DEBOUNCE_CYCLES) bits and `hold_cnt` is clog2(LONG_PRESS_CYCLES) bits; both unsigned and never wrap.
- Long-press fires only while `button_level`=1. Saturation guarantees a single firing per press.
- A bounce back from RELEASE_PENDING never re-fires long-press.

## Timing
- Reset values: `button_level`=0, all pulses=0, `press_count`=0, state RELEASED, `db_cnt`=`hold_cnt`=0.
- Reset asserted mid-operation returns everything to reset values immediately, with no release pulse. A button held through reset deassertion is accepted as a new press after full latency.
- Press latency: `button_level` rises and `press_pulse` is high after the (DEBOUNCE_CYCLES+3)-th rising edge, counting the edge that first samples `button_raw`=1. Release latency is symmetric.
- All pulses are exactly one clock wide and registered. `press_pulse` is coincident with the `button_level` rise.
- `long_press_pulse` is asserted LONG_PRESS_CYCLES−1 edges after `press_pulse`.
- Any input glitch shorter than DEBOUNCE_CYCLES clocks at `sync_2` produces no output change.
- Pulses are mutually exclusive; no two are ever high together.

## Structure
- Shared package `button_pkg` holds:
  - state encoding localparams: RELEASED=2'd0, PRESS_PENDING=2'd1, PRESSED=2'd2, RELEASE_PENDING=2'd3;
  - default cycle constants for 12 MHz.
- Sub-module `sync_2ff`: a generic two-flop synchroniser (clock, reset_n, d, q). It is reused for the second board button.
- FSM, counters and output registers live in `button_debouncer`.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
- Clean press, then clean release 20 clocks later:
  - `button_level` rises on edge 7 from the first raw sample and `press_pulse` is one cycle high there.
  - `press_count`=1.
  - `release_pulse` fires 7 edges after raw falls.
- Bounce at press (raw 1,0,1,0 each for 2 clocks, then steady 1): no pulse during the bounce; exactly one `press_pulse`; `press_count`=1.
- Hold 30 clocks: `long_press_pulse` fires exactly once, 9 edges after `press_pulse`, and never again.
- 3-clock low glitch while held: `button_level` stays 1, no `release_pulse`, no second `long_press_pulse`.
- 256 clean presses: `press_count` wraps to 0 and `press_pulse` count is 256.
- `reset_n` low mid-press (state PRESSED): all outputs 0 asynchronously with no `release_pulse`. Raw is held high through deassertion, so a new `press_pulse` occurs 7 edges later.
